// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the arbiter and the single-port memory.
interface rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_load;
  logic              d_store;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, d_load, d_store, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, d_rdata, d_done, mem_addr, mem_wdata, mem_re, mem_we, bus_err
  );

  modport master (
    output if_req, if_addr, d_load, d_store, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, d_rdata, d_done, mem_addr, mem_wdata, mem_re, mem_we, bus_err
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Fetch vs load/store arbiter for one single-port memory; request-to-pulse >= 2 cycles.
// Strobes held until mem_ready; after TIMEOUT not-ready cycles the access aborts with bus_err.
module rv32i_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  rv32i_mem_arbiter_if.slave    bus
);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_last_data;
  logic                r_is_store;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_re;
  logic                r_mem_we;
  logic                r_if_valid;
  logic                r_d_done;
  logic                r_bus_err;

  logic w_if_req;
  logic w_d_req;
  logic w_grant_fetch;
  logic w_grant_data;
  logic w_timeout;
  logic w_finish;

  // A requester whose pulse is visible this cycle is dropping its request on this edge.
  assign w_if_req      = bus.if_req & ~r_if_valid;
  assign w_d_req       = (bus.d_load | bus.d_store) & ~r_d_done;
  assign w_grant_fetch = w_if_req & (~w_d_req | r_last_data);
  assign w_grant_data  = w_d_req & ~w_grant_fetch;
  assign w_timeout     = TMO_EN && (r_cnt == CNT_W'(TIMEOUT)) && !bus.mem_ready;
  assign w_finish      = bus.mem_ready | w_timeout;

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_data <= 1'b0;
      r_is_store  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_d_done    <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_done   <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_fetch) begin
            r_state     <= S_FETCH;
            r_mem_addr  <= bus.if_addr;
            r_mem_re    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_is_store  <= 1'b0;
            r_last_data <= 1'b0;
            r_cnt       <= '0;
          end else if (w_grant_data) begin
            r_state     <= S_DATA;
            r_mem_addr  <= bus.d_addr;
            r_mem_re    <= ~bus.d_store;
            r_mem_we    <= bus.d_store;
            r_is_store  <= bus.d_store;
            r_last_data <= 1'b1;
            r_cnt       <= '0;
            if (bus.d_store) r_mem_wdata <= bus.d_wdata;
          end
        end
        S_FETCH: begin
          if (w_finish) begin
            r_state    <= S_IDLE;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_valid <= 1'b1;
            r_bus_err  <= ~bus.mem_ready;
            r_if_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_finish) begin
            r_state   <= S_IDLE;
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_d_done  <= 1'b1;
            r_bus_err <= ~bus.mem_ready;
            if (!bus.mem_ready)  r_d_rdata <= '0;
            else if (!r_is_store) r_d_rdata <= bus.mem_rdata;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.bus_err   = r_bus_err;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_rv32i_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic sys_clk   = 1'b0;
  logic sys_reset = 1'b0;
  always #5 sys_clk = ~sys_clk;

  rv32i_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if();

  rv32i_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .bus      (bus_if)
  );

  int total = 0;
  int bad   = 0;

  // Model: the access in flight (kind, cycles waited) and the outputs it implies.
  bit          m_busy;
  int          m_kind;      // 0 fetch, 1 load, 2 store
  int          m_wait;
  bit          m_last_data;
  logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
  logic        e_mem_re, e_mem_we, e_if_valid, e_d_done, e_bus_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_kind = 0; m_wait = 0; m_last_data = 0;
    e_if_rdata = '0; e_d_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
    e_mem_re = 0; e_mem_we = 0; e_if_valid = 0; e_d_done = 0; e_bus_err = 0;
  endtask

  task automatic model_step();
    bit ifv_now, dd_now, fok, dok, err;
    ifv_now = e_if_valid;
    dd_now  = e_d_done;
    e_if_valid = 0; e_d_done = 0; e_bus_err = 0;
    if (!m_busy) begin
      fok = bus_if.if_req && !ifv_now;
      dok = (bus_if.d_load || bus_if.d_store) && !dd_now;
      if (fok && (!dok || m_last_data)) begin
        m_busy = 1; m_kind = 0; m_wait = 0; m_last_data = 0;
        e_mem_addr = bus_if.if_addr; e_mem_re = 1; e_mem_we = 0;
      end else if (dok) begin
        m_busy = 1; m_kind = bus_if.d_store ? 2 : 1; m_wait = 0; m_last_data = 1;
        e_mem_addr = bus_if.d_addr;
        if (bus_if.d_store) e_mem_wdata = bus_if.d_wdata;
        e_mem_re = !bus_if.d_store; e_mem_we = bus_if.d_store;
      end
    end else if (bus_if.mem_ready || m_wait == TMO) begin
      err = !bus_if.mem_ready;
      m_busy = 0; e_mem_re = 0; e_mem_we = 0; e_bus_err = err;
      if (m_kind == 0) begin
        e_if_valid = 1;
        e_if_rdata = err ? 32'h0 : bus_if.mem_rdata;
      end else begin
        e_d_done = 1;
        if (err) e_d_rdata = 32'h0;
        else if (m_kind == 1) e_d_rdata = bus_if.mem_rdata;
      end
    end else begin
      m_wait++;
    end
  endtask

  task automatic compare_all();
    chk("if_rdata",  bus_if.if_rdata,  e_if_rdata);
    chk("d_rdata",   bus_if.d_rdata,   e_d_rdata);
    chk("mem_addr",  bus_if.mem_addr,  e_mem_addr);
    chk("mem_wdata", bus_if.mem_wdata, e_mem_wdata);
    chk("mem_re",    bus_if.mem_re,    e_mem_re);
    chk("mem_we",    bus_if.mem_we,    e_mem_we);
    chk("if_valid",  bus_if.if_valid,  e_if_valid);
    chk("d_done",    bus_if.d_done,    e_d_done);
    chk("bus_err",   bus_if.bus_err,   e_bus_err);
    chk("re_we_excl",    bus_if.mem_re & bus_if.mem_we,   1'b0);
    chk("pulse_excl",    bus_if.if_valid & bus_if.d_done, 1'b0);
  endtask

  // Advance one clock: update the model from the inputs held this cycle, then check after the edge.
  task automatic cycle();
    if (!sys_reset) model_reset();
    else            model_step();
    @(posedge sys_clk);
    #1;
    compare_all();
  endtask

  initial begin
    bit slow;
    int k;
    bus_if.if_req = 0; bus_if.if_addr = '0;
    bus_if.d_load = 0; bus_if.d_store = 0; bus_if.d_addr = '0; bus_if.d_wdata = '0;
    bus_if.mem_rdata = '0; bus_if.mem_ready = 0;
    model_reset();
    cycle();
    cycle();
    chk("rst_mem_re", bus_if.mem_re, 1'b0);
    chk("rst_if_valid", bus_if.if_valid, 1'b0);

    // First fetch straight out of reset.
    sys_reset = 1;
    bus_if.if_req = 1; bus_if.if_addr = 32'h0; bus_if.mem_ready = 1; bus_if.mem_rdata = 32'h13;
    cycle();
    chk("t1_re", bus_if.mem_re, 1'b1);
    chk("t1_addr", bus_if.mem_addr, 32'h0);
    cycle();
    chk("t1_valid", bus_if.if_valid, 1'b1);
    chk("t1_rdata", bus_if.if_rdata, 32'h13);
    chk("t1_err", bus_if.bus_err, 1'b0);

    // Data beats fetch, then fetch wins over a re-asserted load.
    bus_if.if_req = 1; bus_if.if_addr = 32'h40;
    bus_if.d_load = 1; bus_if.d_addr = 32'h100; bus_if.mem_rdata = 32'h1111_2222;
    cycle();
    chk("t2_data_addr", bus_if.mem_addr, 32'h100);
    chk("t2_data_re", bus_if.mem_re, 1'b1);
    cycle();
    chk("t2_done", bus_if.d_done, 1'b1);
    chk("t2_rdata", bus_if.d_rdata, 32'h1111_2222);
    bus_if.mem_rdata = 32'h93;
    cycle();
    chk("t2_fetch_addr", bus_if.mem_addr, 32'h40);
    chk("t2_fetch_re", bus_if.mem_re, 1'b1);
    cycle();
    chk("t2_fvalid", bus_if.if_valid, 1'b1);
    chk("t2_frdata", bus_if.if_rdata, 32'h93);
    bus_if.if_req = 0;
    cycle();
    cycle();
    chk("t2_done2", bus_if.d_done, 1'b1);
    bus_if.d_load = 0;
    cycle();

    // Store with three wait cycles.
    bus_if.d_store = 1; bus_if.d_addr = 32'h200; bus_if.d_wdata = 32'hDEAD_BEEF;
    bus_if.mem_ready = 0; bus_if.mem_rdata = 32'h5555_5555;
    cycle();
    for (int i = 1; i <= 4; i++) begin
      chk("t3_we", bus_if.mem_we, 1'b1);
      chk("t3_addr", bus_if.mem_addr, 32'h200);
      chk("t3_wdata", bus_if.mem_wdata, 32'hDEAD_BEEF);
      bus_if.mem_ready = (i == 4);
      cycle();
    end
    chk("t3_done", bus_if.d_done, 1'b1);
    chk("t3_we_off", bus_if.mem_we, 1'b0);
    chk("t3_rdata_kept", bus_if.d_rdata, 32'h93);
    bus_if.d_store = 0; bus_if.mem_ready = 0;
    cycle();

    // Load that times out.
    bus_if.d_load = 1; bus_if.d_addr = 32'h300;
    cycle();
    for (int i = 1; i <= 5; i++) begin
      chk("t4_re_held", bus_if.mem_re, 1'b1);
      cycle();
    end
    chk("t4_done", bus_if.d_done, 1'b1);
    chk("t4_err", bus_if.bus_err, 1'b1);
    chk("t4_rdata_zero", bus_if.d_rdata, 32'h0);
    chk("t4_re_off", bus_if.mem_re, 1'b0);
    bus_if.d_load = 0;
    cycle();
    chk("t4_re_stays_off", bus_if.mem_re, 1'b0);

    // Load+store resolves to a store; reset mid-access drops it, then it is re-granted.
    bus_if.d_load = 1; bus_if.d_store = 1; bus_if.d_addr = 32'h400; bus_if.d_wdata = 32'hCAFE_F00D;
    cycle();
    chk("t5_we", bus_if.mem_we, 1'b1);
    chk("t5_re", bus_if.mem_re, 1'b0);
    cycle();
    chk("t5_we_held", bus_if.mem_we, 1'b1);
    sys_reset = 0;
    #1;
    model_reset();
    compare_all();
    chk("t5_rst_we", bus_if.mem_we, 1'b0);
    chk("t5_rst_done", bus_if.d_done, 1'b0);
    chk("t5_rst_err", bus_if.bus_err, 1'b0);
    cycle();
    sys_reset = 1; bus_if.mem_ready = 1;
    cycle();
    chk("t5_regrant_we", bus_if.mem_we, 1'b1);
    chk("t5_regrant_addr", bus_if.mem_addr, 32'h400);
    cycle();
    chk("t5_done", bus_if.d_done, 1'b1);
    chk("t5_no_err", bus_if.bus_err, 1'b0);
    bus_if.d_load = 0; bus_if.d_store = 0; bus_if.mem_ready = 0;
    cycle();

    // Random traffic; periodic slow-memory windows provoke timeouts.
    for (int n = 0; n < 4000; n++) begin
      slow = ((n / 200) % 2) == 1;
      bus_if.mem_ready = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      bus_if.mem_rdata = $urandom;
      if (e_if_valid) bus_if.if_req = 0;
      else if (!bus_if.if_req && $urandom_range(0, 2) == 0) begin
        bus_if.if_req  = 1;
        bus_if.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (e_d_done) begin
        bus_if.d_load = 0; bus_if.d_store = 0;
      end else if (!bus_if.d_load && !bus_if.d_store && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        bus_if.d_load  = (k != 1);
        bus_if.d_store = (k != 0);
        bus_if.d_addr  = $urandom;
        bus_if.d_wdata = $urandom;
      end
      if (n % 1000 == 999) begin
        sys_reset = 0;
        #1;
        model_reset();
        compare_all();
        cycle();
        sys_reset = 1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
